// File: rtl/fsm_input_conditioner.sv
// Input front-end for the sequence-detector FSM: synchronizes and debounces
// the raw switch (w) and push-button (step), and counts step pulses.

// Per-input lane: two-flop synchronizer followed by a four-state debounce FSM.
module fsm_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic lvl
);
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1, s2;
  state_t           st;
  logic [CNT_W-1:0] cnt;

  // Synchronizer plus debounce FSM; lvl is registered alongside the state so it
  // changes on the very edge the FSM settles into the opposite stable state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      st  <= STABLE_LO;
      cnt <= '0;
      lvl <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      case (st)
        STABLE_LO: if (s2) begin
          st  <= WAIT_HI;
          cnt <= '0;
        end
        WAIT_HI: begin
          if (!s2) begin
            st  <= STABLE_LO;
            cnt <= '0;
          end else if (cnt == LAST) begin
            st  <= STABLE_HI;
            cnt <= '0;
            lvl <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: if (!s2) begin
          st  <= WAIT_LO;
          cnt <= '0;
        end
        WAIT_LO: begin
          if (s2) begin
            st  <= STABLE_HI;
            cnt <= '0;
          end else if (cnt == LAST) begin
            st  <= STABLE_LO;
            cnt <= '0;
            lvl <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          st  <= STABLE_LO;
          cnt <= '0;
          lvl <= 1'b0;
        end
      endcase
    end
  end
endmodule

module fsm_input_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_raw,
  input  logic       btn_raw,
  output logic       w,
  output logic       step,
  output logic [7:0] step_count
);
  localparam int NUM_IN = 2;   // lane 0 = switch, lane 1 = button

  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] lvl;
  logic              btn_d;
  logic              press;

  assign raw = {btn_raw, sw_raw};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    fsm_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .lvl   (lvl[i])
    );
  end

  // The switch level is already a flop inside its lane.
  assign w     = lvl[0];
  assign press = lvl[1] & ~btn_d;

  // Rising-edge detect on the debounced button; step and count update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_d      <= 1'b0;
      step       <= 1'b0;
      step_count <= 8'd0;
    end else begin
      btn_d <= lvl[1];
      step  <= press;
      if (press) step_count <= step_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Randomized + directed bench for fsm_input_conditioner with a scoreboard.
module tb_fsm_input_conditioner;
  localparam int DB = 4;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_raw = 1'b0;
  logic       btn_raw = 1'b0;
  logic       w, step;
  logic [7:0] step_count;

  fsm_input_conditioner #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .w          (w),
    .step       (step),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       w;
  } ev_t;

  ev_t        exp_q[$];
  bit         hsw[$], hbtn[$];   // raw values sampled at each edge since reset
  int         cyc = 0;
  bit         m_sw, m_btn, m_rose;
  logic [7:0] m_cnt = 8'd0;
  int         n_cmp = 0, n_bad = 0, n_steps = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // The debounce logic only ever sees the raw level from two edges earlier.
  function automatic bit seen(input bit is_btn, input int t);
    int i;
    i = t - 2;
    if (i < 0) return 1'b0;
    return is_btn ? hbtn[i] : hsw[i];
  endfunction

  // True when the last DB+1 samples seen by the debouncer all equal v.
  function automatic bit run_of(input bit is_btn, input int t, input bit v);
    for (int j = t - DB; j <= t; j++)
      if (seen(is_btn, j) != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    int t;
    bit stp;
    cyc++;
    if (!reset) begin
      hsw.delete(); hbtn.delete(); exp_q.delete();
      m_sw = 0; m_btn = 0; m_rose = 0; m_cnt = 8'd0;
      return;
    end
    hsw.push_back(sw_raw);
    hbtn.push_back(btn_raw);
    t = hsw.size() - 1;
    stp = m_rose;
    if (stp) m_cnt = m_cnt + 8'd1;
    if (!m_sw && run_of(1'b0, t, 1'b1)) m_sw = 1;
    else if (m_sw && run_of(1'b0, t, 1'b0)) m_sw = 0;
    m_rose = 0;
    if (!m_btn && run_of(1'b1, t, 1'b1)) begin m_btn = 1; m_rose = 1; end
    else if (m_btn && run_of(1'b1, t, 1'b0)) m_btn = 0;
    if (stp) exp_q.push_back('{cyc, m_cnt, m_sw});
  endtask

  // Driver sits at the falling edge; each tick holds inputs for one cycle.
  task automatic tick(input bit sw, input bit btn);
    sw_raw  = sw;
    btn_raw = btn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input bit sw, input bit btn);
    for (int i = 0; i < n; i++) tick(sw, btn);
  endtask

  task automatic hit_reset(input int n, input bit sw, input bit btn);
    reset = 1'b0;
    #1;
    check("rst_w", w, 0);
    check("rst_step", step, 0);
    check("rst_count", step_count, 0);
    ticks(n, sw, btn);
    reset = 1'b1;
  endtask

  // Monitor: compares w/count every cycle and pops an expected event per step pulse.
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check("w", w, m_sw);
        check("step_count", step_count, m_cnt);
        if (step) begin
          n_steps++;
          if (exp_q.size() == 0) check("step_spurious", step, 0);
          else begin
            ev = exp_q.pop_front();
            check("step_cycle", cyc, ev.cyc);
            check("step_cnt", step_count, ev.cnt);
            check("step_w", w, ev.w);
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          check("step_missing", step, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int s0;
    bit rs, rb;
    @(negedge clk);
    mon_en = 1'b1;
    hit_reset(3, 0, 0);

    // clean switch edges
    ticks(5, 0, 0); ticks(20, 1, 0); ticks(20, 0, 0);

    // one press so the count is non-zero, then reset mid-debounce with sw held
    ticks(10, 0, 1); ticks(10, 0, 0);
    ticks(3, 1, 0);
    hit_reset(2, 1, 0);
    ticks(12, 1, 0); ticks(12, 0, 0);

    // glitches: shorter than DB+1 rejected, exactly DB+1 accepted
    ticks(3, 0, 1); ticks(10, 0, 0);
    ticks(4, 1, 0); ticks(10, 0, 0);
    ticks(4, 0, 1); ticks(10, 0, 0);
    ticks(5, 0, 1); ticks(10, 0, 0);
    ticks(5, 1, 0); ticks(10, 0, 0);

    // press and hold, release gives nothing
    ticks(50, 0, 1); ticks(20, 0, 0);

    // count wrap
    s0 = n_steps;
    for (int p = 0; p < 257; p++) begin ticks(6, 0, 1); ticks(6, 0, 0); end
    ticks(5, 0, 0);
    check("wrap_pulses", n_steps - s0, 257);

    // simultaneous rise
    ticks(20, 1, 1); ticks(20, 0, 0);

    // button held through reset release
    ticks(3, 0, 1);
    hit_reset(2, 0, 1);
    ticks(15, 0, 1); ticks(10, 0, 0);

    // random toggling with occasional resets
    rs = 0; rb = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) rs = ~rs;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      if ($urandom_range(0, 299) == 0) hit_reset($urandom_range(1, 2), rs, rb);
      else tick(rs, rb);
    end

    ticks(20, 0, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
